// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, configurable wait states,
// byte/half/word lanes with load extension and access-error flagging.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  ctrl_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  // In IDLE the live inputs describe the access; afterwards the latched copy does.
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_ctrl;
  assign cur_we    = (state_q == StIdle) ? req_we    : we_q;
  assign cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  assign cur_ctrl  = (state_q == StIdle) ? req_ctrl  : ctrl_q;

  logic accept, enter_resp;
  assign accept     = (state_q == StIdle) && req_valid;
  assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));

  logic ctrl_bad, misalign, out_of_range, acc_err;
  always_comb begin
    ctrl_bad = 1'b0;
    misalign = 1'b0;
    case (cur_ctrl)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = cur_addr[0];
      3'b010:         misalign = |cur_addr[1:0];
      default:        ctrl_bad = 1'b1;
    endcase
    if (cur_we && cur_ctrl[2]) ctrl_bad = 1'b1;
  end
  assign out_of_range = |cur_addr[31:AW+2];
  assign acc_err      = ctrl_bad | misalign | out_of_range;

  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    lbyte;
  logic [15:0]   lhalf;
  logic [31:0]   load_val;
  assign widx  = cur_addr[AW+1:2];
  assign rword = mem_q[widx];
  assign lbyte = rword[{cur_addr[1:0], 3'b000} +: 8];
  assign lhalf = cur_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = '0;
    case (cur_ctrl)
      3'b000:  load_val = {{24{lbyte[7]}}, lbyte};
      3'b100:  load_val = {24'b0, lbyte};
      3'b001:  load_val = {{16{lhalf[15]}}, lhalf};
      3'b101:  load_val = {16'b0, lhalf};
      3'b010:  load_val = rword;
      default: load_val = '0;
    endcase
  end

  logic [3:0]  be;
  logic [31:0] wal, merged;
  logic        mem_we;
  always_comb begin
    be  = 4'b1111;
    wal = cur_wdata;
    case (cur_ctrl[1:0])
      2'b00: begin
        be  = 4'b0001 << cur_addr[1:0];
        wal = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be  = cur_addr[1] ? 4'b1100 : 4'b0011;
        wal = {2{cur_wdata[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        wal = cur_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wal[8*i +: 8] : rword[8*i +: 8];
    end
  end
  assign mem_we = enter_resp && cur_we && !acc_err;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = 4'(WAIT_STATES);
    end else if (state_q == StWait) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (acc_err || cur_we) ? 32'd0 : load_val;
      err_d   = acc_err;
    end else if ((state_q == StResp) && rsp_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        ctrl_q  <= req_ctrl;
      end
    end
  end

  // Contents survive reset; a reset edge suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[widx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = (WAIT_STATES == 0) ? StResp : StWait;
      StWait: if (cnt_q == 4'd1) state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan plus random traffic against a byte-level memory model,
// and a second zero-wait-state instance for back-to-back throughput.
module tb_dmem_responder;
  localparam int unsigned WS     = 2;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned DEPTH1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_ctrl;

  logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [2:0]  req_ctrl1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .WAIT_STATES(0)) dut0ws (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_ctrl(req_ctrl1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  int checks = 0;
  int fails  = 0;
  logic [31:0] mem_m [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, legality rules, little-endian byte placement.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] ctrl, output logic [31:0] rd, output logic er);
    int unsigned size;
    int unsigned sh;
    logic [31:0] w;
    size = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    er = !(ctrl inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && ctrl[2]) ||
         ((addr % size) != 0) || (addr >= 4 * DEPTH);
    rd = '0;
    if (er) return;
    w  = mem_m[addr / 4];
    sh = (addr % 4) * 8;
    if (we) begin
      for (int i = 0; i < int'(size); i++) w[(sh + 8 * i) +: 8] = wdata[8 * i +: 8];
      mem_m[addr / 4] = w;
    end else begin
      rd = w >> sh;
      if (size == 1) begin
        rd = rd & 32'hFF;
        if (!ctrl[2] && rd[7]) rd = rd | 32'hFFFF_FF00;
      end else if (size == 2) begin
        rd = rd & 32'hFFFF;
        if (!ctrl[2] && rd[15]) rd = rd | 32'hFFFF_0000;
      end
    end
  endfunction

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] ctrl, input int hold, input bit keep, input string tag);
    logic [31:0] erd;
    logic        eer;
    int          n;
    model(we, addr, wdata, ctrl, erd, eer);
    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_ctrl = ctrl;
    @(negedge clk);
    if (!keep) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_ctrl = 3'($urandom);
    end
    for (int k = 0; k < int'(WS); k++) begin
      check({tag, ":wait_valid"}, rsp_valid, 0);
      check({tag, ":wait_ready"}, req_ready, 0);
      @(negedge clk);
    end
    check({tag, ":valid"}, rsp_valid, 1);
    check({tag, ":resp_ready"}, req_ready, 0);
    check({tag, ":rdata"}, rsp_rdata, erd);
    check({tag, ":err"}, rsp_err, eer);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, rsp_valid, 1);
      check({tag, ":hold_ready"}, req_ready, 0);
      check({tag, ":hold_rdata"}, rsp_rdata, erd);
      check({tag, ":hold_err"}, rsp_err, eer);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, ":done_valid"}, rsp_valid, 0);
    check({tag, ":done_ready"}, req_ready, 1);
    check({tag, ":done_rdata"}, rsp_rdata, 0);
    check({tag, ":done_err"}, rsp_err, 0);
  endtask

  initial begin
    logic [31:0] a, d, erd;
    logic [2:0]  c;
    logic        w, eer;
    logic [31:0] d1 [4];

    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_ctrl = 0;
    rsp_ready = 0;
    req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0; req_ctrl1 = 0; rsp_ready1 = 1;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    rst_n = 1'b1;

    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rspready_valid", rsp_valid, 0);
    check("idle_rspready_ready", req_ready, 1);
    rsp_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      xact(1'b1, 32'(i * 4), (i == 8) ? 32'd0 : $urandom, 3'b010, 0, 1'b0, "init");
    end

    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, 1'b0, "sw10");
    xact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, "lw10");
    xact(1'b1, 32'h11, 32'h0000_00A5, 3'b000, 1, 1'b0, "sb11");
    xact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, "lw10_b");
    xact(1'b0, 32'h11, 32'h0, 3'b000, 0, 1'b0, "lb11");
    xact(1'b0, 32'h11, 32'h0, 3'b100, 0, 1'b0, "lbu11");
    xact(1'b0, 32'h12, 32'h0, 3'b001, 0, 1'b0, "lh12");
    xact(1'b0, 32'h12, 32'h0, 3'b101, 0, 1'b0, "lhu12");
    xact(1'b1, 32'h16, 32'h1234_8765, 3'b001, 0, 1'b0, "sh16");
    xact(1'b0, 32'h14, 32'h0, 3'b010, 0, 1'b0, "lw14");

    xact(1'b0, 32'h12, 32'h0, 3'b010, 0, 1'b0, "err_lw_mis");
    xact(1'b0, 32'h13, 32'h0, 3'b001, 0, 1'b0, "err_lh_mis");
    xact(1'b1, 32'h10, 32'h55, 3'b100, 0, 1'b0, "err_sbu");
    xact(1'b1, 32'h12, 32'h77, 3'b010, 0, 1'b0, "err_sw_mis");
    xact(1'b0, 32'h1000, 32'h0, 3'b010, 0, 1'b0, "err_range");
    xact(1'b0, 32'h10, 32'h0, 3'b011, 0, 1'b0, "err_ctrl");
    xact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, "lw10_after_err");

    xact(1'b0, 32'h10, 32'h0, 3'b010, 5, 1'b1, "backpressure");

    // Reset lands on the edge that would have committed the store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_ctrl = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (int'(WS) - 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_wait_valid", rsp_valid, 0);
    check("rst_wait_ready", req_ready, 1);
    rst_n = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 3'b010, 0, 1'b0, "lw20_dropped");

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hCAFE_F00D;
    req_ctrl = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (int'(WS)) @(negedge clk);
    check("rst_resp_valid_before", rsp_valid, 1);
    model(1'b1, 32'h24, 32'hCAFE_F00D, 3'b010, erd, eer);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", rsp_valid, 0);
    check("rst_resp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    xact(1'b0, 32'h24, 32'h0, 3'b010, 0, 1'b0, "lw24_kept");

    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
      c = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (c == 3'b000 && $urandom_range(0, 1) == 1) c = 3'b100;
      if (c == 3'b001 && $urandom_range(0, 1) == 1) c = 3'b101;
      w = 1'($urandom);
      d = $urandom;
      xact(w, a, d, c, $urandom_range(0, 3), 1'($urandom), "rand");
    end

    // Zero-wait-state instance: request held valid, one access per two cycles.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("ws0_ready", req_ready1, 1);
      check("ws0_idle_valid", rsp_valid1, 0);
      req_valid1 = 1'b1;
      req_we1    = (i % 2 == 0);
      req_addr1  = 32'((i / 2) * 4);
      req_ctrl1  = 3'b010;
      if (req_we1) d1[i / 2] = $urandom;
      req_wdata1 = req_we1 ? d1[i / 2] : $urandom;
      @(negedge clk);
      check("ws0_valid", rsp_valid1, 1);
      check("ws0_resp_ready", req_ready1, 0);
      check("ws0_rdata", rsp_rdata1, req_we1 ? 32'd0 : d1[i / 2]);
      check("ws0_err", rsp_err1, 0);
      @(negedge clk);
    end
    req_we1 = 1'b0; req_addr1 = 32'h40; req_ctrl1 = 3'b010;
    @(negedge clk);
    check("ws0_range_valid", rsp_valid1, 1);
    check("ws0_range_err", rsp_err1, 1);
    check("ws0_range_rdata", rsp_rdata1, 0);
    req_valid1 = 1'b0;
    @(negedge clk);
    check("ws0_end_valid", rsp_valid1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
